// File: rtl/adder_fault_bist.sv
// Built-in self test for a WIDTH-bit ripple-carry adder. It injects stuck-at faults on the
// sum and carry nodes, runs every input vector against a golden sum and reports the error count per fault.
module adder_fault_bist #(
  parameter int WIDTH = 4,
  localparam int NF      = 4 * WIDTH,
  localparam int FAULT_W = $clog2(NF + 1),
  localparam int CNT_W   = 2 * WIDTH + 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mode,
  input  logic [FAULT_W-1:0] fault_sel,
  output logic               busy,
  output logic               res_valid,
  output logic [FAULT_W-1:0] res_fault,
  output logic [CNT_W-1:0]   res_errcnt,
  output logic               res_detected,
  output logic               done
);

  localparam int K_W = 2 * WIDTH + 1;
  localparam logic [FAULT_W-1:0] NF_C = FAULT_W'(NF);

  typedef enum logic [1:0] {IDLE, RUN, REPORT, DONE} state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [FAULT_W-1:0] fault_q, fault_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [CNT_W-1:0]   err_q, err_d;
  logic [FAULT_W-1:0] res_fault_q, res_fault_d;
  logic [CNT_W-1:0]   res_errcnt_q, res_errcnt_d;
  logic               res_detected_q, res_detected_d;

  // Faulted adder evaluated on the current vector.
  logic [WIDTH-1:0]   a_v, b_v, sum_v;
  logic               cin_v, carry, s_bit;
  logic [FAULT_W-1:0] eff_fault, f_idx, f_bit;
  logic [WIDTH:0]     faulty, golden;
  logic               mismatch;
  logic [CNT_W-1:0]   err_inc;

  always_comb begin
    a_v   = k_q[WIDTH-1:0];
    b_v   = k_q[2*WIDTH-1:WIDTH];
    cin_v = k_q[2*WIDTH];
    // Out-of-range codes run fault-free but are still reported as sampled.
    eff_fault = (fault_q <= NF_C) ? fault_q : '0;
    f_idx     = eff_fault - FAULT_W'(1);
    f_bit     = f_idx >> 2;
    sum_v     = '0;
    carry     = cin_v;
    for (int i = 0; i < WIDTH; i++) begin
      s_bit = a_v[i] ^ b_v[i] ^ carry;
      carry = (a_v[i] & b_v[i]) | (carry & (a_v[i] ^ b_v[i]));
      if (eff_fault != '0 && f_bit == FAULT_W'(i)) begin
        case (f_idx[1:0])
          2'd0:    s_bit = 1'b0;
          2'd1:    s_bit = 1'b1;
          2'd2:    carry = 1'b0;
          default: carry = 1'b1;
        endcase
      end
      sum_v[i] = s_bit;
    end
    faulty   = {carry, sum_v};
    golden   = (WIDTH+1)'(a_v) + (WIDTH+1)'(b_v) + (WIDTH+1)'(cin_v);
    mismatch = (faulty != golden);
    err_inc  = err_q + CNT_W'(mismatch);
  end

  always_comb begin
    // NOTE: every next-state variable gets its hold value first so no path infers a latch.
    state_d        = state_q;
    mode_d         = mode_q;
    fault_d        = fault_q;
    k_d            = k_q;
    err_d          = err_q;
    res_fault_d    = res_fault_q;
    res_errcnt_d   = res_errcnt_q;
    res_detected_d = res_detected_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        mode_d  = mode;
        fault_d = mode ? '0 : fault_sel;
        k_d     = '0;
        err_d   = '0;
      end
      RUN: begin
        k_d   = k_q + K_W'(1);
        err_d = err_inc;
        if (k_q == '1) begin
          // Results are latched on the last vector so they are ready during REPORT.
          state_d        = REPORT;
          res_fault_d    = fault_q;
          res_errcnt_d   = err_inc;
          res_detected_d = (err_inc != '0);
        end
      end
      REPORT: begin
        if (mode_q && fault_q < NF_C) begin
          state_d = RUN;
          fault_d = fault_q + FAULT_W'(1);
          k_d     = '0;
          err_d   = '0;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      mode_q         <= 1'b0;
      fault_q        <= '0;
      k_q            <= '0;
      err_q          <= '0;
      res_fault_q    <= '0;
      res_errcnt_q   <= '0;
      res_detected_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      mode_q         <= mode_d;
      fault_q        <= fault_d;
      k_q            <= k_d;
      err_q          <= err_d;
      res_fault_q    <= res_fault_d;
      res_errcnt_q   <= res_errcnt_d;
      res_detected_q <= res_detected_d;
    end
  end

  assign busy         = (state_q == RUN) || (state_q == REPORT);
  assign res_valid    = (state_q == REPORT);
  assign done         = (state_q == DONE);
  assign res_fault    = res_fault_q;
  assign res_errcnt   = res_errcnt_q;
  assign res_detected = res_detected_q;

endmodule

// File: tb/tb_adder_fault_bist.sv
// Scoreboard bench for adder_fault_bist: the driver queues expected reports from an
// arithmetic fault model and a negedge monitor compares whatever the DUT presents.
module tb_adder_fault_bist;

  localparam int WIDTH   = 2;
  localparam int NF      = 4 * WIDTH;
  localparam int FAULT_W = $clog2(NF + 1);
  localparam int CNT_W   = 2 * WIDTH + 2;
  localparam int V       = 1 << (2 * WIDTH + 1);

  typedef struct {
    int fault;
    int errcnt;
    int cyc;
  } rep_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               start = 1'b0;
  logic               mode = 1'b0;
  logic [FAULT_W-1:0] fault_sel = '0;
  logic               busy, res_valid, res_detected, done;
  logic [FAULT_W-1:0] res_fault;
  logic [CNT_W-1:0]   res_errcnt;

  int   n_pass = 0;
  int   n_total = 0;
  int   cycle_cnt = 0;
  int   done_seen = 0;
  rep_t rep_q[$];
  int   done_q[$];

  adder_fault_bist #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .fault_sel(fault_sel),
    .busy(busy), .res_valid(res_valid), .res_fault(res_fault), .res_errcnt(res_errcnt),
    .res_detected(res_detected), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // Reference: carry-chain behaviour from place-value arithmetic, not gate level.
  function automatic int model_err(input int f);
    int eff, cnt, a, b, cin, gold, res, j, t, m;
    eff = (f <= NF) ? f : 0;
    cnt = 0;
    for (int v = 0; v < V; v++) begin
      a    = v % (1 << WIDTH);
      b    = (v >> WIDTH) % (1 << WIDTH);
      cin  = v >> (2 * WIDTH);
      gold = a + b + cin;
      res  = gold;
      if (eff != 0) begin
        j = (eff - 1) / 4;
        t = (eff - 1) % 4;
        m = 1 << (j + 1);
        case (t)
          0: res = gold & ~(1 << j);
          1: res = gold | (1 << j);
          default: res = ((a % m + b % m + cin) % m) + (((a >> (j + 1)) + (b >> (j + 1)) + (t - 2)) << (j + 1));
        endcase
      end
      if (res != gold) cnt++;
    end
    return cnt;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (res_valid) begin
        if (rep_q.size() == 0) check("unexpected_report", 1, 0);
        else begin
          rep_t e;
          e = rep_q.pop_front();
          check("res_fault", res_fault, e.fault);
          check("res_errcnt", res_errcnt, e.errcnt);
          check("res_detected", res_detected, (e.errcnt != 0) ? 1 : 0);
          check("report_cycle", cycle_cnt, e.cyc);
        end
      end
      if (done) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else check("done_cycle", cycle_cnt, done_q.pop_front());
        done_seen++;
      end
    end
  end

  task automatic run(input bit m, input int fsel, input bit poke);
    int c0, npass, f, seen0, budget, waited;
    seen0 = done_seen;
    @(negedge clk);
    start = 1'b1; mode = m; fault_sel = FAULT_W'(fsel);
    c0 = cycle_cnt + 1;
    npass = m ? NF + 1 : 1;
    for (int p = 0; p < npass; p++) begin
      f = m ? p : fsel;
      rep_q.push_back('{fault: f, errcnt: model_err(f), cyc: c0 + V + p * (V + 1)});
    end
    done_q.push_back(c0 + V + (npass - 1) * (V + 1) + 1);
    @(negedge clk);
    start = 1'b0; mode = 1'($urandom); fault_sel = FAULT_W'($urandom);
    if (poke) begin
      repeat (V / 2) @(negedge clk);
      start = 1'b1; mode = ~m;
      @(negedge clk);
      start = 1'b0;
    end
    budget = npass * (V + 1) + 10;
    waited = 0;
    while (done_seen == seen0 && waited < budget) begin
      @(posedge clk);
      waited++;
    end
    if (done_seen == seen0) check("done_timeout", 0, 1);
    @(negedge clk);
    check("hold_res_fault", res_fault, f);
    check("idle_busy", busy, 0);
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_res_valid"}, res_valid, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_res_fault"}, res_fault, 0);
    check({tag, "_res_errcnt"}, res_errcnt, 0);
    check({tag, "_res_detected"}, res_detected, 0);
  endtask

  initial begin
    #3;
    check_zero_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("idle_after_reset", busy, 0);

    run(1'b0, 0, 1'b0);
    run(1'b0, 4, 1'b0);
    run(1'b0, 8, 1'b0);
    run(1'b0, 1, 1'b1);
    run(1'b0, 15, 1'b0);
    run(1'b1, 0, 1'b1);
    for (int i = 0; i < 6; i++) run(1'b0, int'($urandom_range(0, (1 << FAULT_W) - 1)), 1'($urandom));

    // Reset mid-RUN: nothing queued, so any later report or done is flagged.
    @(negedge clk);
    start = 1'b1; mode = 1'b0; fault_sel = FAULT_W'(3);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_zero_outputs("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * V) @(negedge clk);
    check("stay_idle_busy", busy, 0);

    run(1'b0, 2, 1'b0);
    check("reports_left", rep_q.size(), 0);
    check("dones_left", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
